pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
Two-stage pipelined carry-lookahead adder with valid/ready handshakes on input and output.
- Stage 1 registers the per-bit generate/propagate pairs: g = a&b, p = a^b, i.e. one half-adder cell per bit.
- Stage 2 resolves carries with 4-bit lookahead groups, rippling carry between groups, and registers sum, carry-out and signed overflow.
- Sits downstream of the operand source and upstream of any result consumer; it is the registered, flow-controlled wrapper around the team's half-adder/CLA datapath.

Parameters:
WIDTH, 16, operand and sum width in bits. Must be a multiple of 4 and ≥ 4; anything else is a static configuration error.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  a/b/cin valid this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  sum/cout/overflow valid
out_ready  input  1  consumer accepts result this cycle
sum  output  WIDTH  (a+b+cin) mod 2^WIDTH
cout  output  1  carry out of MSB
overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at a rising edge): v1=0, v2=0, out_valid=0, sum=0, cout=0, overflow=0. Stage-1 data registers are cleared to 0.
- in_ready is 0 while rst=1.
- Reset mid-operation discards all in-flight results; no result for them ever appears.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- Stage-1 regs: g[WIDTH-1:0], p[WIDTH-1:0], c0, v1. Loaded on input transfer with g=a&b, p=a^b, c0=cin.
- Stage-2 regs: sum, cout, overflow, v2 (v2 drives out_valid).
- Advance rules:
  - adv2 = v1 & (!v2 | out_ready).
  - ready1 = !v1 | adv2.
  - in_ready = ready1 & !rst. This is a combinational path from out_ready, which is permitted.
- Next-state rules:
  - v1_next = input transfer ? 1 : (adv2 ? 0 : v1).
  - v2_next = adv2 ? 1 : (out_ready ? 0 : v2).
- Carry logic in stage 2, per group k of 4 bits with group carry-in Ck (C0 = c0):
  - c[i+1] = g[i] | p[i]&c[i], expanded to flat lookahead form within the group.
  - Group G/P computed; C(k+1) = Gk | Pk&Ck.
  - sum[i] = p[i] ^ c[i]; cout = c[WIDTH]; overflow = c[WIDTH-1] ^ c[WIDTH].
- Latency: a result is visible on out_valid 2 cycles after its input transfer when not stalled.
- Throughput: 1 result per cycle with out_ready held high.
- Stall: while out_valid=1 and out_ready=0, sum/cout/overflow hold stable. Stage 1 holds one more operand set, so in_ready=0 only when both stages are full and out_ready=0.
- Simultaneous input transfer and stage-1 drain in the same cycle: stage 1 is reloaded with the new operand and v1 stays 1.
- Ordering: results leave in strict acceptance order. No drop, no duplicate.
- No combinational path from a/b/cin to sum.

Test Plan:
- Reset, then a=16'hFFFF, b=16'h0001, cin=0, out_ready=1 -> exactly 2 cycles later out_valid=1, sum=16'h0000, cout=1, overflow=0.
- a=16'h7FFF, b=16'h0000, cin=1 (carry ripples across all 4 groups) -> sum=16'h8000, cout=0, overflow=1. Also a=16'h8000, b=16'h8000, cin=0 -> sum=0, cout=1, overflow=1.
- Back-to-back stream of 8 operand pairs, out_ready=1 -> 8 consecutive out_valid cycles, results in order, in_ready constantly 1.
- out_ready=0 with 3 inputs offered -> first 2 accepted, in_ready=0 on the third, sum held stable. Raise out_ready -> all 3 emerge in order, none lost or duplicated.
- Assert rst for 1 cycle while both stages are valid -> next cycle out_valid=0, sum=0, in_ready=1. The flushed results never appear.
- Random 10k operand sets with random in_valid/out_ready, WIDTH=16 and WIDTH=32 -> every result equals a reference model of a+b+cin (sum, cout, overflow) in order.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready flow control.
// Stage 1 registers per-bit generate/propagate; stage 2 resolves 4-bit lookahead groups.
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NG = WIDTH / 4;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [WIDTH-1:0] g_q, p_q;
    logic             c0_q, v1_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, v2_q;

    logic             adv2, ready1, in_xfer;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d;
    logic [3:0]       gi, pi;
    logic             ck, grp_g, grp_p;

    assign adv2     = v1_q & (~v2_q | out_ready);
    assign ready1   = ~v1_q | adv2;
    assign in_ready = ready1 & ~rst;
    assign in_xfer  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q  <= '0;
            p_q  <= '0;
            c0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            if (in_xfer) begin
                g_q  <= a & b;
                p_q  <= a ^ b;
                c0_q <= cin;
            end
            v1_q <= in_xfer ? 1'b1 : (adv2 ? 1'b0 : v1_q);
        end
    end

    // Flat lookahead inside each 4-bit group; group carries ripple group to group.
    always_comb begin
        c     = '0;
        gi    = '0;
        pi    = '0;
        ck    = 1'b0;
        grp_g = 1'b0;
        grp_p = 1'b0;
        c[0]  = c0_q;
        for (int k = 0; k < NG; k++) begin
            gi = g_q[4*k +: 4];
            pi = p_q[4*k +: 4];
            ck = c[4*k];
            c[4*k+1] = gi[0] | (pi[0] & ck);
            c[4*k+2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ck);
            c[4*k+3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                     | (pi[2] & pi[1] & pi[0] & ck);
            grp_g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
                  | (pi[3] & pi[2] & pi[1] & gi[0]);
            grp_p = &pi;
            c[4*k+4] = grp_g | (grp_p & ck);
        end
    end

    assign sum_d  = p_q ^ c[WIDTH-1:0];
    assign cout_d = c[WIDTH];
    assign ovf_d  = c[WIDTH-1] ^ c[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            if (adv2) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
            v2_q <= adv2 ? 1'b1 : (out_ready ? 1'b0 : v2_q);
        end
    end

    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors and flow-control sequences on a
// 16-bit instance, plus random traffic on 16- and 32-bit instances with scoreboards.
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv16, ir16, c16, ov16, ordy16, co16, of16;
    logic [15:0] a16, b16, s16;
    logic        iv32, ir32, c32, ov32, ordy32, co32, of32;
    logic [31:0] a32, b32, s32;

    pipelined_cla_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(c16),
        .out_valid(ov16), .out_ready(ordy16), .sum(s16), .cout(co16), .overflow(of16));
    pipelined_cla_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(c32),
        .out_valid(ov32), .out_ready(ordy32), .sum(s32), .cout(co32), .overflow(of32));

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] sum;
        logic        cout, ovf;
    } vec_t;

    int   errors = 0, checks = 0;
    int   pops16 = 0, pops32 = 0;
    res_t q16[$], q32[$];

    function automatic res_t ref_model(input int w, input logic [31:0] x, input logic [31:0] y,
                                       input logic ci);
        res_t        r;
        logic [32:0] s;
        logic [32:0] mask;
        s      = {1'b0, x} + {1'b0, y} + {32'b0, ci};
        mask   = (33'd1 << w) - 33'd1;
        r.sum  = 32'(s & mask);
        r.cout = s[w];
        r.ovf  = (x[w-1] == y[w-1]) && (r.sum[w-1] != x[w-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transfers are predicted at the negedge: inputs only change just after posedge.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q16.delete();
            q32.delete();
        end else begin
            if (ov16 && ordy16) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL sb16_unexpected: got sum=%h with no result pending", s16);
                end else begin
                    e = q16.pop_front();
                    pops16++;
                    if ({s16, co16, of16} !== {e.sum[15:0], e.cout, e.ovf}) begin
                        errors++;
                        $display("FAIL sb16: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                 s16, co16, of16, e.sum[15:0], e.cout, e.ovf);
                    end
                end
            end
            if (iv16 && ir16) q16.push_back(ref_model(16, {16'b0, a16}, {16'b0, b16}, c16));
            if (ov32 && ordy32) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL sb32_unexpected: got sum=%h with no result pending", s32);
                end else begin
                    e = q32.pop_front();
                    pops32++;
                    if ({s32, co32, of32} !== {e.sum, e.cout, e.ovf}) begin
                        errors++;
                        $display("FAIL sb32: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                 s32, co32, of32, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (iv32 && ir32) q32.push_back(ref_model(32, a32, b32, c32));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        iv16 = 1'b1; a16 = x; b16 = y; c16 = ci;
    endtask

    vec_t        vecs[11];
    logic [15:0] held;
    int          base, highs, rises, n;
    logic        prev;

    initial begin
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[6]  = '{16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1};
        vecs[7]  = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[8]  = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[9]  = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1;
        iv16 = 0; a16 = '0; b16 = '0; c16 = 0; ordy16 = 1;
        iv32 = 0; a32 = '0; b32 = '0; c32 = 0; ordy32 = 1;
        tick(); tick();
        chk("reset_out_valid", 32'(ov16), 32'd0);
        chk("reset_sum", 32'(s16), 32'd0);
        chk("reset_cout_ovf", 32'({co16, of16}), 32'd0);
        chk("reset_in_ready_low", 32'(ir16), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(ir16), 32'd1);

        // Single vectors: 2-cycle latency and exact results.
        foreach (vecs[i]) begin
            tick();
            drive16(vecs[i].a, vecs[i].b, vecs[i].cin);
            tick();
            iv16 = 1'b0;
            chk($sformatf("vec%0d_lat1_no_valid", i), 32'(ov16), 32'd0);
            tick();
            chk($sformatf("vec%0d_lat2_valid", i), 32'(ov16), 32'd1);
            chk($sformatf("vec%0d_result", i), 32'({s16, co16, of16}),
                32'({vecs[i].sum, vecs[i].cout, vecs[i].ovf}));
        end
        repeat (3) tick();

        // Back-to-back stream of 8 with out_ready high.
        highs = 0; rises = 0; prev = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    tick();
                    drive16(16'($urandom), 16'($urandom), 1'($urandom));
                    #1;
                    chk($sformatf("stream_in_ready%0d", i), 32'(ir16), 32'd1);
                end
                tick();
                iv16 = 1'b0;
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    if (ov16) highs++;
                    if (ov16 && !prev) rises++;
                    prev = ov16;
                end
            end
        join
        chk("stream_valid_cycles", 32'(highs), 32'd8);
        chk("stream_contiguous", 32'(rises), 32'd1);

        // Stall: two accepted, third refused, output held.
        base = pops16;
        ordy16 = 1'b0;
        tick();
        drive16(16'h1111, 16'h0001, 1'b0);
        #1; chk("stall_rdy0", 32'(ir16), 32'd1);
        tick();
        drive16(16'h2222, 16'h0002, 1'b1);
        #1; chk("stall_rdy1", 32'(ir16), 32'd1);
        tick();
        drive16(16'h3333, 16'h0003, 1'b0);
        #1; chk("stall_rdy2_low", 32'(ir16), 32'd0);
        chk("stall_out_valid", 32'(ov16), 32'd1);
        held = s16;
        chk("stall_first_sum", 32'(held), 32'h1112);
        repeat (3) tick();
        chk("stall_still_blocked", 32'(ir16), 32'd0);
        chk("stall_sum_stable", 32'(s16), 32'(held));
        ordy16 = 1'b1;
        #1; chk("stall_release_rdy", 32'(ir16), 32'd1);
        tick();
        iv16 = 1'b0;
        n = 0;
        while (pops16 < base + 3 && n < 10) begin tick(); n++; end
        repeat (2) tick();
        chk("stall_drain_count", 32'(pops16 - base), 32'd3);

        // Reset with both stages full: flushed results never emerge.
        ordy16 = 1'b0;
        tick();
        drive16(16'h4444, 16'h0004, 1'b0);
        tick();
        drive16(16'h5555, 16'h0005, 1'b0);
        tick();
        iv16 = 1'b0;
        chk("flush_full_valid", 32'(ov16), 32'd1);
        chk("flush_full_blocked", 32'(ir16), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("flush_out_valid", 32'(ov16), 32'd0);
        chk("flush_sum", 32'(s16), 32'd0);
        chk("flush_in_ready", 32'(ir16), 32'd1);
        base = pops16;
        ordy16 = 1'b1;
        repeat (6) tick();
        chk("flush_no_results", 32'(pops16 - base), 32'd0);

        // Random traffic on both widths.
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    tick();
                    iv16 = ($urandom_range(0, 3) != 0);
                    a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
                    ordy16 = ($urandom_range(0, 3) != 0);
                end
                tick();
                iv16 = 1'b0; ordy16 = 1'b1;
            end
            begin
                for (int i = 0; i < 10000; i++) begin
                    tick();
                    iv32 = ($urandom_range(0, 2) != 0);
                    a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
                    ordy32 = ($urandom_range(0, 2) != 0);
                end
                tick();
                iv32 = 1'b0; ordy32 = 1'b1;
            end
        join
        n = 0;
        while ((q16.size() != 0 || q32.size() != 0) && n < 20) begin tick(); n++; end
        chk("drain_q16_empty", 32'(q16.size()), 32'd0);
        chk("drain_q32_empty", 32'(q32.size()), 32'd0);
        chk("random16_progress", 32'(pops16 > 5000), 32'd1);
        chk("random32_progress", 32'(pops32 > 4000), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
